piano_key_encoder: RTL and testbench
====================================

// Module: piano_key_encoder
// PURPOSE
//  Front end of the piano datapath: synchronises and debounces the raw key switches,
//  then encodes them into the 8-bit note code consumed by the note/indicator logic.
//  Code 0 = no key, 1..NUM_KEYS = single key k-1, 99 = rest/chord (several keys down).
//  Emits a one-cycle strobe on every code change; feeds the player, buzzer and note lights.
// PARAMETERS
//  NUM_KEYS        21       number of key inputs; legal range 1..98
//  DEBOUNCE_CYCLES 1000000  clocks between debounce samples (20 ms @ 50 MHz); >=2
//  CODE_REST       8'd99    code driven when more than one key is down
// PORTS
//  iClk        in   1         system clock, single domain
//  iReset_n    in   1         asynchronous, active-low reset
//  iKeys       in   NUM_KEYS  raw key switches, active high, asynchronous, may bounce
//  iEnable     in   1         power/enable switch; low forces the output code to 0
//  oNote       out  8         registered note code (0 / 1..NUM_KEYS / CODE_REST)
//  oNoteValid  out  1         1-cycle pulse, same cycle oNote takes a new value
//  oKeyHeld    out  1         high while oNote != 0
// BEHAVIOUR
//  Reset (async assert, sync release): oNote=0, oNoteValid=0, oKeyHeld=0, sync flops,
//   sample registers, tick counter and FSM cleared (FSM=IDLE). Mid-operation reset
//   discards all history; the first press after release needs full debounce.
//  Sync: 2-flop synchroniser per key bit.
//  Tick: counter 0..DEBOUNCE_CYCLES-1; tick=1 for one cycle when counter wraps to 0.
//  Debounce per key: on tick, shift synced bit into 3-bit history. Stable level =
//   1 if history==3'b111, 0 if 3'b000, else previous stable level (hold).
//  Encode (comb. on stable vector S): popcount(S)==0 -> 0; ==1 -> index+1;
//   >=2 -> CODE_REST. Popcount saturates at 2; no priority between keys.
//  FSM states IDLE (code 0), NOTE (single key), CHORD (CODE_REST):
//   next state selected from the encoder every cycle; NOTE->NOTE with a different
//   index is a legal transition (legato) and counts as a change.
//   iEnable=0 -> next state IDLE, next code 0, regardless of S; debounce keeps running
//   so re-enabling with a key held yields that key's code on the next cycle.
//  Output register: oNote <= next code; oNoteValid <= (next code != oNote);
//   oKeyHeld <= (next code != 0). No pulse when the code is unchanged.
//  Latency: raw edge -> oNote = 2 sync cycles + 3 to 4 ticks + 1 cycle.
//   A glitch shorter than 3 consecutive samples never changes oNote.
//  Simultaneous release of one key and press of another inside the same tick gives
//   a direct NOTE->NOTE change; an IDLE is not inserted.
// STRUCTURE
//  Shared package: note-code constants (NOTE_NONE=0, NOTE_REST=99), FSM state
//   encoding, DEBOUNCE_CYCLES default. The note/indicator logic consumes the same
//   constants.
//  Sub-module key_debounce_cell (sync + 3-bit history + stable flag), instantiated
//   NUM_KEYS times in a generate loop. Tick counter, encoder and FSM live in the top.
// TESTING  (DEBOUNCE_CYCLES=4, NUM_KEYS=21 in sim)
//  1 Reset: pulse iReset_n low mid-cycle -> all outputs 0 immediately (async); after
//    release with no keys, oNote stays 0 and oNoteValid never pulses.
//  2 Clean press: iKeys[4]=1 held -> oNote=5, one oNoteValid pulse, oKeyHeld=1 within
//    2+4*4+1 cycles; release -> oNote=0 with one pulse, oKeyHeld=0.
//  3 Bounce: toggle iKeys[0] every 3 cycles for 40 cycles, then hold 1 -> oNote goes
//    0 -> 1 exactly once, no intermediate pulses.
//  4 Chord: hold iKeys[2], then add iKeys[7] -> oNote 3 -> 99; release iKeys[2]
//    -> 99 -> 8; each transition gives exactly one pulse.
//  5 Enable: hold iKeys[10], drop iEnable -> next cycle oNote=0 with pulse; raise
//    iEnable -> next cycle oNote=11 with pulse.
//  6 Max index: iKeys[20] only -> oNote=21; every key pressed -> oNote=99.

Source files
------------

// File: rtl/piano_key_encoder_pkg.sv
// -----------------------------------------------------------------------------
// piano_key_encoder_pkg
//  Shared definitions for the piano key front end and the note/indicator logic:
//  note-code type and constants, FSM state encoding and the default debounce
//  sample period.
// -----------------------------------------------------------------------------
package piano_key_encoder_pkg;

    typedef logic [7:0] noteCode_t;

    localparam noteCode_t NOTE_NONE = 8'd0;   // no key down (or disabled)
    localparam noteCode_t NOTE_REST = 8'd99;  // several keys down

    // 20 ms between debounce samples at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // code NOTE_NONE
        NOTE  = 2'd1,   // single key, code 1..NUM_KEYS
        CHORD = 2'd2    // code NOTE_REST
    } keyState_t;

endpackage

// File: rtl/piano_key_encoder_if.sv
// -----------------------------------------------------------------------------
// piano_key_encoder_if
//  Note-code bus from the key encoder to its consumers (player, buzzer, lights).
//   note       8  registered note code
//   noteValid  1  one-cycle pulse when note takes a new value
//   keyHeld    1  high while note != NOTE_NONE
//  master: the encoder driving the bus; slave: a consumer.
// -----------------------------------------------------------------------------
interface piano_key_encoder_if;
    import piano_key_encoder_pkg::*;

    noteCode_t note;
    logic      noteValid;
    logic      keyHeld;

    modport master (output note, output noteValid, output keyHeld);
    modport slave  (input  note, input  noteValid, input  keyHeld);
endinterface

// File: rtl/piano_key_encoder_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce_cell
//  One key: 2-flop synchroniser, 3-sample history taken on each debounce tick,
//  and a stable level that only moves after three equal consecutive samples.
//   iClk      in   system clock
//   iReset_n  in   asynchronous active-low reset
//   iTick     in   one-cycle debounce sample strobe
//   iKey      in   raw key switch (asynchronous, may bounce)
//   oStable   out  debounced key level
// -----------------------------------------------------------------------------
module key_debounce_cell (
    input  logic iClk,
    input  logic iReset_n,
    input  logic iTick,
    input  logic iKey,
    output logic oStable
);
    logic [1:0] syncQ;
    logic [2:0] history;
    logic [2:0] historyNext;

    assign historyNext = {history[1:0], syncQ[1]};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // values from before the clock edge; blocking here would collapse the
    // synchroniser stages into one.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            syncQ   <= '0;
            history <= '0;
            oStable <= 1'b0;
        end else begin
            syncQ <= {syncQ[0], iKey};
            if (iTick) begin
                history <= historyNext;
                // Judge the history including the sample just taken; mixed
                // histories hold the previous level.
                if (historyNext == 3'b111)
                    oStable <= 1'b1;
                else if (historyNext == 3'b000)
                    oStable <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/piano_key_encoder.sv
// -----------------------------------------------------------------------------
// piano_key_encoder
//  Debounces the raw key switches and encodes them into an 8-bit note code:
//  0 = no key, 1..NUM_KEYS = single key k-1, CODE_REST = several keys down.
//   iClk      in   system clock, single domain
//   iReset_n  in   asynchronous active-low reset
//   iKeys     in   raw key switches, active high, asynchronous
//   iEnable   in   enable switch; low forces code 0 (debounce keeps running)
//   noteBus   master modport: note, noteValid, keyHeld (all registered)
// -----------------------------------------------------------------------------
module piano_key_encoder
    import piano_key_encoder_pkg::*;
#(
    parameter int        NUM_KEYS        = 21,  // 1..98
    parameter int        DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,  // >= 2
    parameter noteCode_t CODE_REST       = NOTE_REST
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    input  logic [NUM_KEYS-1:0]   iKeys,
    input  logic                  iEnable,
    piano_key_encoder_if.master   noteBus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TICK_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0]       tickCount;
    logic                tick;
    logic [NUM_KEYS-1:0] stableKeys;
    logic [1:0]          hits;      // popcount saturated at 2
    noteCode_t           keyIdx;
    keyState_t           state;
    keyState_t           nextState;
    noteCode_t           nextCode;

    // ---------------- debounce sample tick ----------------
    assign tick = (tickCount == TICK_LAST);

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n)
            tickCount <= '0;
        else if (tick)
            tickCount <= '0;
        else
            tickCount <= tickCount + 1'b1;
    end

    // ---------------- per-key debounce ----------------
    for (genvar k = 0; k < NUM_KEYS; k++) begin : gKey
        key_debounce_cell uCell (
            .iClk     (iClk),
            .iReset_n (iReset_n),
            .iTick    (tick),
            .iKey     (iKeys[k]),
            .oStable  (stableKeys[k])
        );
    end

    // ---------------- encoder + next state ----------------
    // NOTE: every variable written in this always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hits      = 2'd0;
        keyIdx    = NOTE_NONE;
        nextState = IDLE;
        nextCode  = NOTE_NONE;

        for (int k = 0; k < NUM_KEYS; k++) begin
            if (stableKeys[k]) begin
                if (hits == 2'd0) begin
                    hits   = 2'd1;
                    keyIdx = noteCode_t'(k);
                end else begin
                    hits = 2'd2;
                end
            end
        end

        if (iEnable) begin
            case (hits)
                2'd0:    begin nextState = IDLE;  nextCode = NOTE_NONE;  end
                2'd1:    begin nextState = NOTE;  nextCode = keyIdx + 8'd1; end
                default: begin nextState = CHORD; nextCode = CODE_REST;  end
            endcase
        end
    end

    // ---------------- FSM + registered outputs ----------------
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state             <= IDLE;
            noteBus.note      <= NOTE_NONE;
            noteBus.noteValid <= 1'b0;
            noteBus.keyHeld   <= 1'b0;
        end else begin
            state             <= nextState;
            noteBus.note      <= nextCode;
            // A state change, or a legato NOTE->NOTE move to another key.
            noteBus.noteValid <= (nextState != state) ||
                                 (nextState == NOTE && nextCode != noteBus.note);
            noteBus.keyHeld   <= (nextState != IDLE);
        end
    end
endmodule

// File: tb/tb_piano_key_encoder.sv
// -----------------------------------------------------------------------------
// tb_piano_key_encoder
//  Directed bench for piano_key_encoder with DEBOUNCE_CYCLES=4, NUM_KEYS=21.
// -----------------------------------------------------------------------------
module tb_piano_key_encoder;
    localparam int NK     = 21;
    localparam int SETTLE = 30;   // comfortably above 2 + 4*4 + 1 cycles

    logic          clk = 1'b0;
    logic          rstN;
    logic [NK-1:0] keys;
    logic          enable;

    int checks = 0;
    int errors = 0;
    int pulses;

    piano_key_encoder_if bus ();

    piano_key_encoder #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (4),
        .CODE_REST       (8'd99)
    ) dut (
        .iClk     (clk),
        .iReset_n (rstN),
        .iKeys    (keys),
        .iEnable  (enable),
        .noteBus  (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NK-1:0] keys;
        logic          enable;
        int            expNote;
        int            expHeld;
        int            expPulses;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Run n cycles sampling on the falling edge, counting noteValid pulses.
    task automatic settle(input int n);
        repeat (n) begin
            @(negedge clk);
            if (bus.noteValid) pulses++;
        end
    endtask

    initial begin
        int lat;

        // row: keys, enable, expected note, expected held, expected pulses
        vecs[0]  = '{21'h0,              1'b1,  0, 0, 0};
        vecs[1]  = '{21'h1 << 4,         1'b1,  5, 1, 1};
        vecs[2]  = '{21'h0,              1'b1,  0, 0, 1};
        vecs[3]  = '{21'h1,              1'b1,  1, 1, 1};
        vecs[4]  = '{21'h2,              1'b1,  2, 1, 1};  // legato swap
        vecs[5]  = '{21'h1 << 20,        1'b1, 21, 1, 1};
        vecs[6]  = '{21'h1FFFFF,         1'b1, 99, 1, 1};
        vecs[7]  = '{21'h84,             1'b1, 99, 1, 0};  // still a chord
        vecs[8]  = '{21'h80,             1'b1,  8, 1, 1};
        vecs[9]  = '{21'h80,             1'b0,  0, 0, 1};
        vecs[10] = '{21'h80,             1'b1,  8, 1, 1};
        vecs[11] = '{21'h0,              1'b1,  0, 0, 1};

        rstN   = 1'b0;
        keys   = '0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("reset note",  int'(bus.note),      0);
        check("reset valid", int'(bus.noteValid), 0);
        check("reset held",  int'(bus.keyHeld),   0);
        rstN = 1'b1;

        // ---- table-driven vectors ----
        for (int i = 0; i < 12; i++) begin
            keys   = vecs[i].keys;
            enable = vecs[i].enable;
            pulses = 0;
            settle(SETTLE);
            check($sformatf("vec%0d note", i),   int'(bus.note),    vecs[i].expNote);
            check($sformatf("vec%0d held", i),   int'(bus.keyHeld), vecs[i].expHeld);
            check($sformatf("vec%0d pulses", i), pulses,            vecs[i].expPulses);
        end

        // ---- clean press latency ----
        keys[4] = 1'b1;
        lat = 0;
        while (bus.note != 8'd5 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("press latency ok", int'(lat <= 19), 1);
        check("press valid", int'(bus.noteValid), 1);
        check("press held",  int'(bus.keyHeld),   1);
        keys = '0;
        pulses = 0;
        settle(SETTLE);
        check("release note", int'(bus.note), 0);
        check("release pulses", pulses, 1);

        // ---- bounce: period-6 toggling never gives 3 equal samples ----
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) keys[0] = ~keys[0];
            @(negedge clk);
            if (bus.noteValid) pulses++;
        end
        check("bounce quiet", int'(bus.note), 0);
        keys[0] = 1'b1;
        settle(SETTLE);
        check("bounce note", int'(bus.note), 1);
        check("bounce pulses", pulses, 1);
        keys = '0;
        settle(SETTLE);

        // ---- enable drop / raise with key 10 held ----
        keys[10] = 1'b1;
        settle(SETTLE);
        check("en held note", int'(bus.note), 11);
        enable = 1'b0;
        @(negedge clk);
        check("en drop note",  int'(bus.note),      0);
        check("en drop valid", int'(bus.noteValid), 1);
        @(negedge clk);
        check("en drop valid clears", int'(bus.noteValid), 0);
        enable = 1'b1;
        @(negedge clk);
        check("en raise note",  int'(bus.note),      11);
        check("en raise valid", int'(bus.noteValid), 1);
        check("en raise held",  int'(bus.keyHeld),   1);

        // ---- asynchronous reset mid-cycle ----
        @(posedge clk);
        #3 rstN = 1'b0;
        #1;
        check("async rst note",  int'(bus.note),    0);
        check("async rst held",  int'(bus.keyHeld), 0);
        @(negedge clk);
        keys = '0;
        rstN = 1'b1;
        pulses = 0;
        settle(SETTLE);
        check("post rst note", int'(bus.note), 0);
        check("post rst pulses", pulses, 0);

        // ---- after reset the first press needs full debounce ----
        keys[3] = 1'b1;
        pulses = 0;
        settle(8);
        check("post rst early", int'(bus.note), 0);
        settle(SETTLE);
        check("post rst press", int'(bus.note), 4);
        check("post rst press pulses", pulses, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
